// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    // Default geometry: 27 bits covers 99_999_999, the largest 8-digit value
    localparam int DEF_BIN_W  = 27;
    localparam int DEF_DIGITS = 8;

    // Largest value that fits in 8 decimal digits
    localparam logic [26:0] MAX_DEC = 27'd99_999_999;

    // Displayed when the input does not fit in 8 digits
    localparam logic [31:0] SAT_BCD = 32'h9999_9999;

    // Iteration counter width for the default input width
    localparam int CNT_W = $clog2(DEF_BIN_W + 1);

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Inputs 5..9 map to 8..12, so no carry out of the nibble ever occurs
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, fixed latency,
// result held steady in bcd_out between conversions.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4 * DIGITS;

    bcd_state_t     state;
    logic [BIN_W-1:0] shreg;
    logic [BW-1:0]  scratch;
    logic [BW-1:0]  adj;
    logic [BW-1:0]  scratch_nxt;
    logic [BIN_W-1:0] shreg_nxt;
    logic [CW-1:0]  cnt;
    logic           ovf_pending;

    // Per-digit add-3 correction on the current scratch contents
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    // One double-dabble step: corrected scratch and binary shift left as one word
    assign {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;

    // Converter FSM with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            shreg       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            bcd_out     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= bin_in;
                        scratch     <= '0;
                        cnt         <= CW'(BIN_W);
                        ovf_pending <= (bin_in > BIN_W'(MAX_DEC));
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    cnt     <= cnt - 1'b1;
                    // Last iteration: publish the result straight from the step logic
                    if (cnt == CW'(1)) begin
                        bcd_out  <= ovf_pending ? BW'(SAT_BCD) : scratch_nxt;
                        overflow <= ovf_pending;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and sweep checks for bin_to_bcd_seq.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd_out;

    int tests;
    int fails;

    bin_to_bcd_seq dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decimal reference by repeated division, with saturation
    function automatic logic [31:0] ref_bcd(input logic [26:0] v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        if (x > 99_999_999) return 32'h9999_9999;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Start one conversion and wait for done; returns latency and busy-cycle count
    task automatic convert(input logic [26:0] v, output int lat, output int bcyc);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcyc  = 0;
        while (!done && lat < 100) begin
            if (busy) bcyc++;
            @(negedge clk);
            lat++;
        end
        if (busy) bcyc++;
    endtask

    vec_t vecs[9];

    initial begin
        int lat, bcyc, c, ndone, idx, last, cyc;
        logic [26:0] sweep[1000];

        tests  = 0;
        fails  = 0;
        start  = 1'b0;
        bin_in = '0;
        resetn = 1'b0;

        vecs[0] = '{27'd0,           32'h0000_0000, 1'b0};
        vecs[1] = '{27'd12_345_678,  32'h1234_5678, 1'b0};
        vecs[2] = '{27'd9,           32'h0000_0009, 1'b0};
        vecs[3] = '{27'd10,          32'h0000_0010, 1'b0};
        vecs[4] = '{27'd99_999_999,  32'h9999_9999, 1'b0};
        vecs[5] = '{27'd100_000_000, 32'h9999_9999, 1'b1};
        vecs[6] = '{27'd5,           32'h0000_0005, 1'b0};
        vecs[7] = '{27'h7FF_FFFF,    32'h9999_9999, 1'b1};
        vecs[8] = '{27'd1,           32'h0000_0001, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset ovf",  32'(overflow), 32'd0);
        chk("reset bcd",  bcd_out, 32'h0);
        resetn = 1'b1;

        // Table-driven conversions
        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].bin, lat, bcyc);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd28);
            chk($sformatf("vec%0d bcd", i), bcd_out, vecs[i].exp_bcd);
            chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            if (i == 0) begin
                chk("busy cycles", 32'(bcyc), 32'd28);
                @(negedge clk);
                chk("busy after finish", 32'(busy), 32'd0);
                chk("done one cycle", 32'(done), 32'd0);
                chk("bcd held", bcd_out, 32'h0);
            end
        end

        // Starts during SHIFT and during FINISH are ignored
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd12_345_678;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (c = 1; c <= 70; c++) begin
            if (c == 5)  begin start = 1'b1; bin_in = 27'd42; end
            if (c == 6)  start = 1'b0;
            if (c == 28) begin
                chk("ign done at T+28", 32'(done), 32'd1);
                start  = 1'b1;
                bin_in = 27'd42;
            end
            if (c == 29) begin
                chk("ign idle after finish", 32'(busy), 32'd0);
                start = 1'b0;
            end
            if (done) ndone++;
            @(negedge clk);
        end
        chk("ign single done", 32'(ndone), 32'd1);
        chk("ign result", bcd_out, 32'h1234_5678);

        // Reset in the middle of a conversion
        @(negedge clk);
        start  = 1'b1;
        bin_in = 27'd54_321;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (c = 1; c < 10; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst bcd", bcd_out, 32'h0);
        chk("rst done", 32'(done), 32'd0);
        resetn = 1'b1;
        for (c = 0; c < 40; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("rst no done", 32'(ndone), 32'd0);
        convert(27'd7, lat, bcyc);
        chk("post-rst latency", 32'(lat), 32'd28);
        chk("post-rst bcd", bcd_out, 32'h0000_0007);

        // Back-to-back sweep with start held high
        for (int i = 0; i < 1000; i++) sweep[i] = 27'($urandom);
        sweep[0] = 27'd99_999_999;
        sweep[1] = 27'd100_000_000;
        @(negedge clk);
        bin_in = sweep[0];
        start  = 1'b1;
        idx  = 0;
        last = -1;
        cyc  = 0;
        while (idx < 1000 && cyc < 1000 * 29 + 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                chk($sformatf("sweep%0d bcd", idx), bcd_out, ref_bcd(sweep[idx]));
                chk($sformatf("sweep%0d ovf", idx), 32'(overflow),
                    32'(sweep[idx] > 27'd99_999_999));
                if (last >= 0) chk($sformatf("sweep%0d spacing", idx), 32'(cyc - last), 32'd29);
                last = cyc;
                idx++;
                if (idx < 1000) bin_in = sweep[idx];
            end
        end
        start = 1'b0;
        chk("sweep completed", 32'(idx), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
